// File: rtl/pdl_puf_pkg.sv
// Shared constants and evaluation-FSM state encoding for the PDL arbiter PUF.
// The chain/arbiter top imports the same defaults so both ends agree on sizing.
package pdl_puf_pkg;

    localparam int DEF_N_STAGES      = 64;
    localparam int DEF_SETTLE_CYCLES = 8;
    localparam int DEF_N_EVAL        = 15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RISE = 3'd2,
        ST_FALL = 3'd3,
        ST_DONE = 3'd4
    } eval_state_e;

endpackage

// File: rtl/pdl_sync2.sv
// Two-flop synchronizer for the arbiter decision, which is asynchronous to clk.
// Hierarchy is kept so the flop pair stays adjacent and is never retimed or merged.
(* keep_hierarchy = "yes" *)
module pdl_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pdl_eval_ctrl.sv
// PDL arbiter PUF evaluation controller: latches a challenge, runs N_EVAL
// launch/discharge races through the chain and majority-votes the arbiter bit.
module pdl_eval_ctrl
    import pdl_puf_pkg::*;
#(
    parameter int N_STAGES      = DEF_N_STAGES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int N_EVAL        = DEF_N_EVAL
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [N_STAGES-1:0]         chal_top,
    input  logic [N_STAGES-1:0]         chal_btm,
    output logic [N_STAGES-1:0]         sel_tp,
    output logic [N_STAGES-1:0]         sel_btm,
    output logic                        launch,
    input  logic                        arb_out,
    output logic                        busy,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic                        response,
    output logic [$clog2(N_EVAL+1)-1:0] ones_count,
    output logic                        stable
);

    localparam int ONES_W = $clog2(N_EVAL + 1);
    localparam int RACE_W = (N_EVAL > 1) ? $clog2(N_EVAL) : 1;
    localparam int CNT_W  = $clog2(SETTLE_CYCLES);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RACE_W-1:0] RACE_LAST = RACE_W'(N_EVAL - 1);
    localparam logic [ONES_W-1:0] ONES_HALF = ONES_W'(N_EVAL / 2);
    localparam logic [ONES_W-1:0] ONES_ALL  = ONES_W'(N_EVAL);

    eval_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RACE_W-1:0]    race_q, race_d;
    logic [ONES_W-1:0]    ones_q, ones_d;
    logic [N_STAGES-1:0]  sel_tp_q, sel_tp_d;
    logic [N_STAGES-1:0]  sel_btm_q, sel_btm_d;
    logic                 launch_q, launch_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic                 response_q, response_d;
    logic                 stable_q, stable_d;
    logic                 arb_sync;

    pdl_sync2 u_arb_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (arb_out),
        .q     (arb_sync)
    );

    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves a signal unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        race_d     = race_q;
        ones_d     = ones_q;
        sel_tp_d   = sel_tp_q;
        sel_btm_d  = sel_btm_q;
        launch_d   = launch_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        response_d = response_q;
        stable_d   = stable_q;

        unique case (state_q)
            ST_IDLE: begin
                // Selects are captured here so they are already driving the chain in LOAD.
                if (start) begin
                    state_d    = ST_LOAD;
                    sel_tp_d   = chal_top;
                    sel_btm_d  = chal_btm;
                    cnt_d      = '0;
                    race_d     = '0;
                    ones_d     = '0;
                    busy_d     = 1'b1;
                    response_d = 1'b0;
                    stable_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                state_d  = ST_RISE;
                launch_d = 1'b1;
            end
            ST_RISE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_FALL;
                    cnt_d    = '0;
                    launch_d = 1'b0;
                    ones_d   = ones_q + ONES_W'(arb_sync);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FALL: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (race_q == RACE_LAST) begin
                        state_d    = ST_DONE;
                        valid_d    = 1'b1;
                        response_d = (ones_q > ONES_HALF);
                        stable_d   = (ones_q == '0) || (ones_q == ONES_ALL);
                    end else begin
                        state_d  = ST_RISE;
                        race_d   = race_q + RACE_W'(1);
                        launch_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            race_q     <= '0;
            ones_q     <= '0;
            sel_tp_q   <= '0;
            sel_btm_q  <= '0;
            launch_q   <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            response_q <= 1'b0;
            stable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            race_q     <= race_d;
            ones_q     <= ones_d;
            sel_tp_q   <= sel_tp_d;
            sel_btm_q  <= sel_btm_d;
            launch_q   <= launch_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            response_q <= response_d;
            stable_q   <= stable_d;
        end
    end

    assign sel_tp     = sel_tp_q;
    assign sel_btm    = sel_btm_q;
    assign launch     = launch_q;
    assign busy       = busy_q;
    assign resp_valid = valid_q;
    assign response   = response_q;
    assign ones_count = ones_q;
    assign stable     = stable_q;

endmodule
